// File: rtl/vme_a24_d32_responder_if.sv
// VME pin bundle (buffered, split in/out) plus the internal register-bus side
// of the A24/D32 responder.
interface vme_a24_d32_responder_if;
  logic        VME_AS_n_i;
  logic [1:0]  VME_DS_n_i;
  logic        VME_WRITE_n_i;
  logic [5:0]  VME_AM_i;
  logic [5:0]  VME_GA_i;
  logic        VME_LWORD_n_i;
  logic [31:1] VME_ADDR_i;
  logic [31:0] VME_DATA_i;
  logic [31:0] VME_DATA_o;
  logic        VME_DTACK_n_o;
  logic        VME_DTACK_OE_o;
  logic        VME_BERR_o;
  logic        VME_ADDR_DIR_o;
  logic        VME_ADDR_OE_N_o;
  logic        VME_DATA_DIR_o;
  logic        VME_DATA_OE_N_o;
  logic [16:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport slave (
    input  VME_AS_n_i, VME_DS_n_i, VME_WRITE_n_i, VME_AM_i, VME_GA_i,
           VME_LWORD_n_i, VME_ADDR_i, VME_DATA_i, wb_dat_i, wb_ack_i,
    output VME_DATA_o, VME_DTACK_n_o, VME_DTACK_OE_o, VME_BERR_o,
           VME_ADDR_DIR_o, VME_ADDR_OE_N_o, VME_DATA_DIR_o, VME_DATA_OE_N_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o
  );

  modport master (
    output VME_AS_n_i, VME_DS_n_i, VME_WRITE_n_i, VME_AM_i, VME_GA_i,
           VME_LWORD_n_i, VME_ADDR_i, VME_DATA_i, wb_dat_i, wb_ack_i,
    input  VME_DATA_o, VME_DTACK_n_o, VME_DTACK_OE_o, VME_BERR_o,
           VME_ADDR_DIR_o, VME_ADDR_OE_N_o, VME_DATA_DIR_o, VME_DATA_OE_N_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o
  );
endinterface

// File: rtl/vme_a24_d32_responder.sv
// VME64x A24/D32 single-cycle slave: synchronizes the strobes, decodes the slot
// window and runs one register-bus transaction per VME cycle.
module vme_a24_d32_responder #(
  parameter int unsigned g_ack_timeout = 255,
  parameter int unsigned g_sync_stages = 2
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_sys_i,
  vme_a24_d32_responder_if.slave        bus,
  output logic [4:0]                    slot_o,
  output logic                          slot_err_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    STROBE   = 3'd2,
    WAIT_ACK = 3'd3,
    ACK      = 3'd4,
    ERR      = 3'd5,
    RELEASE  = 3'd6
  } state_t;

  localparam logic [9:0] ack_limit = 10'(g_ack_timeout);

  // GA[5] must equal the xor of the decoded slot; slot 0 means no backplane slot.
  function automatic logic ga_bad(input logic [5:0] ga);
    logic [4:0] s;
    s = ~ga[4:0];
    return (ga[5] != ^s) || (s == 5'd0);
  endfunction

  state_t                          state;
  logic [g_sync_stages-1:0]        as_sync;
  logic [g_sync_stages-1:0][1:0]   ds_sync;
  logic [g_sync_stages-1:0]        we_sync;
  logic                            as_prev;
  logic [5:0]                      am_lat;
  logic [23:1]                     a_lat;
  logic                            lword_lat;
  logic                            write_n_lat;
  logic [9:0]                      wait_cnt;

  logic       as_s;
  logic [1:0] ds_s;
  logic       as_fall;
  logic       am_ok;
  logic       hit;
  logic       d32_ok;

  assign as_s    = as_sync[g_sync_stages-1];
  assign ds_s    = ds_sync[g_sync_stages-1];
  assign as_fall = as_prev & ~as_s;
  assign am_ok   = (am_lat == 6'h39) || (am_lat == 6'h3D);
  assign hit     = am_ok && (a_lat[23:19] == slot_o) && !slot_err_o;
  assign d32_ok  = (ds_s == 2'b00) && !lword_lat && !a_lat[1];

  // Strobe synchronizers, edge history and registered slot decode.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      as_sync    <= '1;
      ds_sync    <= '1;
      we_sync    <= '1;
      as_prev    <= 1'b1;
      slot_o     <= 5'd0;
      slot_err_o <= 1'b1;
    end else begin
      as_sync    <= {as_sync[g_sync_stages-2:0], bus.VME_AS_n_i};
      ds_sync    <= {ds_sync[g_sync_stages-2:0], bus.VME_DS_n_i};
      we_sync    <= {we_sync[g_sync_stages-2:0], bus.VME_WRITE_n_i};
      as_prev    <= as_s;
      slot_o     <= ~bus.VME_GA_i[4:0];
      slot_err_o <= ga_bad(bus.VME_GA_i);
    end
  end

  // Cycle FSM with all bus-facing outputs registered.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state               <= IDLE;
      am_lat              <= 6'h00;
      a_lat               <= '0;
      lword_lat           <= 1'b1;
      write_n_lat         <= 1'b1;
      wait_cnt            <= 10'd0;
      bus.VME_DATA_o      <= 32'h0000_0000;
      bus.VME_DTACK_n_o   <= 1'b1;
      bus.VME_DTACK_OE_o  <= 1'b0;
      bus.VME_BERR_o      <= 1'b0;
      bus.VME_ADDR_DIR_o  <= 1'b0;
      bus.VME_ADDR_OE_N_o <= 1'b0;
      bus.VME_DATA_DIR_o  <= 1'b0;
      bus.VME_DATA_OE_N_o <= 1'b0;
      bus.wb_adr_o        <= 17'd0;
      bus.wb_dat_o        <= 32'h0000_0000;
      bus.wb_we_o         <= 1'b0;
      bus.wb_stb_o        <= 1'b0;
    end else begin
      bus.VME_ADDR_DIR_o  <= 1'b0;
      bus.VME_ADDR_OE_N_o <= 1'b0;
      bus.VME_DATA_OE_N_o <= 1'b0;
      case (state)
        IDLE: begin
          if (as_fall) begin
            am_lat      <= bus.VME_AM_i;
            a_lat       <= bus.VME_ADDR_i[23:1];
            lword_lat   <= bus.VME_LWORD_n_i;
            write_n_lat <= we_sync[g_sync_stages-1];
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (as_s) begin
            state <= IDLE;
          end else if (ds_s != 2'b11) begin
            // A miss leaves the bus completely untouched.
            if (!hit) begin
              state <= IDLE;
            end else if (!d32_ok) begin
              bus.VME_BERR_o <= 1'b1;
              state          <= ERR;
            end else begin
              bus.wb_adr_o <= a_lat[18:2];
              bus.wb_we_o  <= ~write_n_lat;
              if (!write_n_lat) begin
                bus.wb_dat_o <= bus.VME_DATA_i;
              end
              state <= STROBE;
            end
          end
        end
        STROBE: begin
          if (as_s) begin
            state <= IDLE;
          end else begin
            bus.wb_stb_o <= 1'b1;
            wait_cnt     <= 10'd0;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          bus.wb_stb_o <= 1'b0;
          if (as_s) begin
            state <= IDLE;
          end else if (bus.wb_ack_i) begin
            if (write_n_lat) begin
              bus.VME_DATA_o     <= bus.wb_dat_i;
              bus.VME_DATA_DIR_o <= 1'b1;
            end
            bus.VME_DTACK_OE_o <= 1'b1;
            bus.VME_DTACK_n_o  <= 1'b0;
            state              <= ACK;
          end else if (wait_cnt == ack_limit) begin
            bus.VME_BERR_o <= 1'b1;
            state          <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        ACK: begin
          if (ds_s == 2'b11) begin
            bus.VME_DTACK_n_o  <= 1'b1;
            bus.VME_DATA_DIR_o <= 1'b0;
            state              <= RELEASE;
          end
        end
        ERR: begin
          if (ds_s == 2'b11) begin
            bus.VME_BERR_o <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          // DTACK was driven high for one cycle on entry; now let it float.
          bus.VME_DTACK_OE_o <= 1'b0;
          bus.VME_DTACK_n_o  <= 1'b1;
          bus.VME_BERR_o     <= 1'b0;
          bus.VME_DATA_DIR_o <= 1'b0;
          if (as_s) begin
            state <= IDLE;
          end
        end
        default: begin
          bus.VME_DTACK_OE_o <= 1'b0;
          bus.VME_DTACK_n_o  <= 1'b1;
          bus.VME_BERR_o     <= 1'b0;
          bus.VME_DATA_DIR_o <= 1'b0;
          bus.wb_stb_o       <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_a24_d32_responder.sv
// Directed bench for vme_a24_d32_responder: inputs driven and outputs sampled
// on the falling clock edge, expectations hand-computed.
module tb_vme_a24_d32_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] slot;
  logic       slot_err;
  int         tests = 0;
  int         fails = 0;

  vme_a24_d32_responder_if bus ();

  vme_a24_d32_responder #(
    .g_ack_timeout (16),
    .g_sync_stages (2)
  ) dut (
    .clk_sys_i  (clk),
    .rst_sys_i  (rst),
    .bus        (bus),
    .slot_o     (slot),
    .slot_err_o (slot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.VME_AS_n_i    = 1'b1;
    bus.VME_DS_n_i    = 2'b11;
    bus.VME_WRITE_n_i = 1'b1;
    bus.VME_LWORD_n_i = 1'b1;
    bus.VME_AM_i      = 6'h00;
    bus.VME_ADDR_i    = 31'd0;
    bus.VME_DATA_i    = 32'h0;
    bus.wb_ack_i      = 1'b0;
    bus.wb_dat_i      = 32'h0;
  endtask

  task automatic vme_start(input logic [5:0] am, input logic [31:0] a32,
                           input logic write_n, input logic [31:0] d, input logic lword_n);
    @(negedge clk);
    bus.VME_AM_i      = am;
    bus.VME_ADDR_i    = a32[31:1];
    bus.VME_WRITE_n_i = write_n;
    bus.VME_DATA_i    = d;
    bus.VME_LWORD_n_i = lword_n;
    bus.VME_AS_n_i    = 1'b0;
  endtask

  // Watch n cycles and report whether any response activity was seen.
  task automatic watch(input int n, output logic saw_stb, output logic saw_oe, output logic saw_berr);
    saw_stb = 1'b0;
    saw_oe = 1'b0;
    saw_berr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      saw_stb  = saw_stb | bus.wb_stb_o;
      saw_oe   = saw_oe | bus.VME_DTACK_OE_o | ~bus.VME_DTACK_n_o;
      saw_berr = saw_berr | bus.VME_BERR_o;
    end
  endtask

  task automatic end_cycle();
    bus_idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a32, input logic [31:0] d, input logic [16:0] exp_adr);
    vme_start(6'h39, a32, 1'b0, d, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    repeat (3) @(negedge clk);
    check("wr_stb_early", 32'(bus.wb_stb_o), 32'd0);
    @(negedge clk);
    check("wr_stb", 32'(bus.wb_stb_o), 32'd1);
    check("wr_adr", 32'(bus.wb_adr_o), 32'(exp_adr));
    check("wr_we", 32'(bus.wb_we_o), 32'd1);
    check("wr_dat", bus.wb_dat_o, d);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check("wr_stb_width", 32'(bus.wb_stb_o), 32'd0);
    check("wr_dtack", 32'(bus.VME_DTACK_n_o), 32'd0);
    check("wr_dtack_oe", 32'(bus.VME_DTACK_OE_o), 32'd1);
    check("wr_data_dir", 32'(bus.VME_DATA_DIR_o), 32'd0);
    bus.VME_DS_n_i = 2'b11;
    repeat (2) @(negedge clk);
    check("wr_dtack_hold", 32'(bus.VME_DTACK_n_o), 32'd0);
    @(negedge clk);
    check("wr_dtack_rel", 32'(bus.VME_DTACK_n_o), 32'd1);
    check("wr_oe_hold", 32'(bus.VME_DTACK_OE_o), 32'd1);
    bus.VME_AS_n_i = 1'b1;
    @(negedge clk);
    check("wr_oe_off", 32'(bus.VME_DTACK_OE_o), 32'd0);
    end_cycle();
  endtask

  task automatic do_read(input logic [31:0] a32, input logic [31:0] rd, input int delay,
                         input logic [16:0] exp_adr);
    vme_start(6'h3D, a32, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    repeat (3) @(negedge clk);
    check("rd_stb_early", 32'(bus.wb_stb_o), 32'd0);
    @(negedge clk);
    check("rd_stb", 32'(bus.wb_stb_o), 32'd1);
    check("rd_adr", 32'(bus.wb_adr_o), 32'(exp_adr));
    check("rd_we", 32'(bus.wb_we_o), 32'd0);
    bus.wb_dat_i = rd;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("rd_wait_stb", 32'(bus.wb_stb_o), 32'd0);
      check("rd_wait_dtack", 32'(bus.VME_DTACK_n_o), 32'd1);
      check("rd_wait_dir", 32'(bus.VME_DATA_DIR_o), 32'd0);
    end
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check("rd_data", bus.VME_DATA_o, rd);
    check("rd_dir", 32'(bus.VME_DATA_DIR_o), 32'd1);
    check("rd_dtack", 32'(bus.VME_DTACK_n_o), 32'd0);
    check("rd_dtack_oe", 32'(bus.VME_DTACK_OE_o), 32'd1);
    bus.VME_DS_n_i = 2'b11;
    repeat (2) @(negedge clk);
    check("rd_dir_hold", 32'(bus.VME_DATA_DIR_o), 32'd1);
    @(negedge clk);
    check("rd_dir_off", 32'(bus.VME_DATA_DIR_o), 32'd0);
    check("rd_dtack_rel", 32'(bus.VME_DTACK_n_o), 32'd1);
    bus.VME_AS_n_i = 1'b1;
    end_cycle();
  endtask

  initial begin
    logic s_stb, s_oe, s_berr;
    bus_idle();
    bus.VME_GA_i = 6'b011010;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dtack", 32'(bus.VME_DTACK_n_o), 32'd1);
    check("rst_dtack_oe", 32'(bus.VME_DTACK_OE_o), 32'd0);
    check("rst_berr", 32'(bus.VME_BERR_o), 32'd0);
    check("rst_data_dir", 32'(bus.VME_DATA_DIR_o), 32'd0);
    check("rst_data_oe_n", 32'(bus.VME_DATA_OE_N_o), 32'd0);
    check("rst_addr_dir", 32'(bus.VME_ADDR_DIR_o), 32'd0);
    check("rst_addr_oe_n", 32'(bus.VME_ADDR_OE_N_o), 32'd0);
    check("rst_data_o", bus.VME_DATA_o, 32'h0);
    check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst_we", 32'(bus.wb_we_o), 32'd0);
    check("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("slot", 32'(slot), 32'd5);
    check("slot_err_ok", 32'(slot_err), 32'd0);

    do_write(32'h0028_0010, 32'hDEAD_BEEF, 17'h00004);
    do_read(32'h0028_0020, 32'h1234_5678, 3, 17'h00008);

    // Slot 6 window, then a non-A24 modifier: both must be ignored.
    vme_start(6'h39, 32'h0030_0000, 1'b0, 32'h1111_2222, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    watch(10, s_stb, s_oe, s_berr);
    check("miss_win_stb", 32'(s_stb), 32'd0);
    check("miss_win_dtack", 32'(s_oe), 32'd0);
    check("miss_win_berr", 32'(s_berr), 32'd0);
    end_cycle();
    vme_start(6'h09, 32'h0028_0010, 1'b0, 32'h3333_4444, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    watch(10, s_stb, s_oe, s_berr);
    check("miss_am_stb", 32'(s_stb), 32'd0);
    check("miss_am_dtack", 32'(s_oe), 32'd0);
    check("miss_am_berr", 32'(s_berr), 32'd0);
    end_cycle();

    // D8 access to our window: bus error until the strobes go away.
    vme_start(6'h39, 32'h0028_0010, 1'b0, 32'h0000_00AA, 1'b1);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b10;
    repeat (2) @(negedge clk);
    check("d8_berr_early", 32'(bus.VME_BERR_o), 32'd0);
    @(negedge clk);
    check("d8_berr", 32'(bus.VME_BERR_o), 32'd1);
    watch(4, s_stb, s_oe, s_berr);
    check("d8_no_stb", 32'(s_stb), 32'd0);
    check("d8_no_dtack", 32'(s_oe), 32'd0);
    bus.VME_DS_n_i = 2'b11;
    repeat (2) @(negedge clk);
    check("d8_berr_hold", 32'(bus.VME_BERR_o), 32'd1);
    @(negedge clk);
    check("d8_berr_rel", 32'(bus.VME_BERR_o), 32'd0);
    end_cycle();

    // No acknowledge: bus error 17 cycles after the strobe.
    vme_start(6'h39, 32'h0028_0030, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    repeat (4) @(negedge clk);
    check("to_stb", 32'(bus.wb_stb_o), 32'd1);
    repeat (16) @(negedge clk);
    check("to_berr_early", 32'(bus.VME_BERR_o), 32'd0);
    @(negedge clk);
    check("to_berr", 32'(bus.VME_BERR_o), 32'd1);
    check("to_no_dtack", 32'(bus.VME_DTACK_OE_o), 32'd0);
    bus.VME_DS_n_i = 2'b11;
    repeat (3) @(negedge clk);
    check("to_berr_rel", 32'(bus.VME_BERR_o), 32'd0);
    end_cycle();

    // Bad GA parity: flagged and never answered.
    bus.VME_GA_i = 6'b111010;
    repeat (2) @(negedge clk);
    check("bad_ga_err", 32'(slot_err), 32'd1);
    vme_start(6'h39, 32'h0028_0010, 1'b0, 32'h5555_6666, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    watch(10, s_stb, s_oe, s_berr);
    check("bad_ga_stb", 32'(s_stb), 32'd0);
    check("bad_ga_dtack", 32'(s_oe), 32'd0);
    check("bad_ga_berr", 32'(s_berr), 32'd0);
    end_cycle();
    bus.VME_GA_i = 6'b011010;
    repeat (2) @(negedge clk);
    check("good_ga_err", 32'(slot_err), 32'd0);

    // Reset pulse while waiting for ack.
    vme_start(6'h39, 32'h0028_0040, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    bus.VME_DS_n_i = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_mid_pre_stb", 32'(bus.wb_stb_o), 32'd1);
    rst = 1'b1;
    bus_idle();
    @(negedge clk);
    check("rst_mid_stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst_mid_adr", 32'(bus.wb_adr_o), 32'd0);
    check("rst_mid_dtack", 32'(bus.VME_DTACK_n_o), 32'd1);
    check("rst_mid_oe", 32'(bus.VME_DTACK_OE_o), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_read(32'h0028_0044, 32'hA5A5_0F0F, 1, 17'h00011);

    // AS released while still decoding: silent abort.
    vme_start(6'h39, 32'h0028_0010, 1'b0, 32'h7777_8888, 1'b0);
    repeat (3) @(negedge clk);
    bus.VME_AS_n_i = 1'b1;
    watch(8, s_stb, s_oe, s_berr);
    check("abort_stb", 32'(s_stb), 32'd0);
    check("abort_dtack", 32'(s_oe), 32'd0);
    check("abort_berr", 32'(s_berr), 32'd0);
    end_cycle();
    do_write(32'h0028_0100, 32'h0BAD_F00D, 17'h00040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
